// File: rtl/d_sram_bridge.sv
// Data-port bridge: turns one M-stage load/store into exactly one SRAM-like
// req/addr_ok/data_ok transaction and stalls the pipeline until it retires.
module d_sram_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_en,
  input  logic [3:0]        cpu_wen,
  input  logic [1:0]        cpu_size,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              cpu_longest_stall,
  input  logic              flush_except,
  output logic              d_stall,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t              state_q, state_d;
  logic                do_finish_q, do_finish_d;
  logic                discard_q, discard_d;
  logic                wr_q, wr_d;
  logic [1:0]          size_q, size_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                start;
  logic                complete;

  assign start = cpu_en & ~do_finish_q & ~flush_except & (state_q == IDLE);

  always_comb begin
    state_d     = state_q;
    do_finish_d = do_finish_q;
    discard_d   = discard_q;
    wr_d        = wr_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    complete    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          size_d  = cpu_size;
          wr_d    = |cpu_wen;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (bus_addr_ok) begin
          if (bus_data_ok) complete = 1'b1;
          else             state_d  = DATA;
        end
      end
      DATA: begin
        if (bus_data_ok) complete = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // An in-flight access cannot be cancelled; remember to drop its result.
    if (state_q != IDLE && flush_except) discard_d = 1'b1;

    // Pipeline advanced (or was flushed while idle): the instruction left M.
    if (!cpu_longest_stall || (state_q == IDLE && flush_except)) do_finish_d = 1'b0;

    if (complete) begin
      state_d = IDLE;
      if (discard_q || flush_except) begin
        discard_d = 1'b0;
      end else begin
        do_finish_d = 1'b1;
        if (!wr_q) rdata_d = bus_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      do_finish_q <= 1'b0;
      discard_q   <= 1'b0;
      wr_q        <= 1'b0;
      size_q      <= 2'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      do_finish_q <= do_finish_d;
      discard_q   <= discard_d;
      wr_q        <= wr_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus_req   = (state_q == ADDR);
  assign bus_wr    = wr_q;
  assign bus_size  = size_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign cpu_rdata = rdata_q;
  assign d_stall   = start | (state_q != IDLE);

endmodule

// File: tb/tb_d_sram_bridge.sv
// Directed bench for d_sram_bridge: transaction-level model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_d_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_longest_stall;
  logic        flush_except;
  logic        d_stall;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  logic        i_stall;

  int n_pass  = 0;
  int n_total = 0;
  int req_cycles = 0;
  int hs_count   = 0;

  always #5 clk = ~clk;

  assign cpu_longest_stall = d_stall | i_stall;

  d_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_size(cpu_size),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_longest_stall(cpu_longest_stall), .flush_except(flush_except),
    .d_stall(d_stall), .bus_req(bus_req), .bus_wr(bus_wr),
    .bus_size(bus_size), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Model: one outstanding transaction record, plus "result delivered" hold.
  bit          mv = 0;
  bit          m_pend, m_acc, m_wait, m_fl, m_wr, e_start, done, fl;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rd;

  always @(negedge clk) begin
    e_start = cpu_en && !m_wait && !flush_except && !m_pend;
    if (mv) begin
      chk("d_stall", d_stall, e_start || m_pend);
      chk("bus_req", bus_req, m_pend && !m_acc);
      chk("cpu_rdata", cpu_rdata, m_rd);
      if (m_pend && !m_acc) begin
        chk("bus_addr", bus_addr, m_addr);
        chk("bus_wdata", bus_wdata, m_wdata);
        chk("bus_size", bus_size, m_size);
        chk("bus_wr", bus_wr, m_wr);
      end
    end
    if (bus_req === 1'b1) req_cycles++;
    if (bus_req === 1'b1 && bus_addr_ok) hs_count++;

    if (rst) begin
      m_pend = 0; m_acc = 0; m_wait = 0; m_fl = 0; m_rd = '0;
      mv = 1;
    end else if (mv) begin
      fl = m_fl || flush_except;
      if (!cpu_longest_stall || (flush_except && !m_pend)) m_wait = 0;
      if (m_pend) begin
        done = bus_data_ok && (m_acc || bus_addr_ok);
        if (bus_addr_ok) m_acc = 1;
        if (flush_except) m_fl = 1;
        if (done) begin
          m_pend = 0; m_acc = 0; m_fl = 0;
          if (!fl) begin
            m_wait = 1;
            if (!m_wr) m_rd = bus_rdata;
          end
        end
      end else if (e_start) begin
        m_pend = 1; m_acc = 0; m_fl = 0;
        m_addr = cpu_addr; m_wdata = cpu_wdata; m_size = cpu_size; m_wr = |cpu_wen;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] wen, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    cpu_en = 1'b1; cpu_wen = wen; cpu_size = sz; cpu_addr = a; cpu_wdata = wd;
  endtask

  int rq0, hs0;

  initial begin
    rst = 1'b1; cpu_en = 0; cpu_wen = 0; cpu_size = 0; cpu_addr = 0; cpu_wdata = 0;
    flush_except = 0; bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0; i_stall = 0;
    cyc(); cyc();
    chk("rst_d_stall", d_stall, 1'b0);
    chk("rst_bus_req", bus_req, 1'b0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    rst = 1'b0;
    cyc();

    // Word load, minimum latency.
    rq0 = req_cycles; hs0 = hs_count;
    issue(4'b0000, 2'd2, 32'h0000_0010, 32'h0); #1;
    chk("t1_c0_d_stall", d_stall, 1'b1);
    chk("t1_c0_req", bus_req, 1'b0);
    cyc(); bus_addr_ok = 1; #1;
    chk("t1_c1_req", bus_req, 1'b1);
    chk("t1_c1_wr", bus_wr, 1'b0);
    chk("t1_c1_size", bus_size, 2'd2);
    chk("t1_c1_addr", bus_addr, 32'h0000_0010);
    cyc(); bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'hDEAD_BEEF; #1;
    chk("t1_c2_d_stall", d_stall, 1'b1);
    chk("t1_c2_req", bus_req, 1'b0);
    cyc(); bus_data_ok = 0; bus_rdata = 0; #1;
    chk("t1_c3_d_stall", d_stall, 1'b0);
    chk("t1_c3_rdata", cpu_rdata, 32'hDEAD_BEEF);
    cyc(); cpu_en = 0;
    cyc();
    chk("t1_req_cycles", req_cycles - rq0, 1);
    chk("t1_handshakes", hs_count - hs0, 1);

    // Byte store with addr_ok held off for three cycles.
    rq0 = req_cycles; hs0 = hs_count;
    issue(4'b0100, 2'd0, 32'h0000_0022, 32'h00AB_0000);
    cyc();
    for (int i = 0; i < 4; i++) begin
      bus_addr_ok = (i == 3); #1;
      chk("t2_req", bus_req, 1'b1);
      chk("t2_addr", bus_addr, 32'h0000_0022);
      chk("t2_wdata", bus_wdata, 32'h00AB_0000);
      chk("t2_wr", bus_wr, 1'b1);
      chk("t2_size", bus_size, 2'd0);
      cyc();
    end
    bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h5555_5555; #1;
    chk("t2_data_d_stall", d_stall, 1'b1);
    cyc(); bus_data_ok = 0; #1;
    chk("t2_done_d_stall", d_stall, 1'b0);
    chk("t2_rdata_kept", cpu_rdata, 32'hDEAD_BEEF);
    cyc(); cpu_en = 0;
    cyc();
    chk("t2_req_cycles", req_cycles - rq0, 4);
    chk("t2_handshakes", hs_count - hs0, 1);

    // Load finishing under an i_stall: no re-issue while held.
    rq0 = req_cycles; hs0 = hs_count;
    issue(4'b0000, 2'd2, 32'h0000_0040, 32'h0);
    cyc(); bus_addr_ok = 1;
    cyc(); bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h1234_5678;
    cyc(); bus_data_ok = 0; i_stall = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_hold_d_stall", d_stall, 1'b0);
      chk("t3_hold_req", bus_req, 1'b0);
      chk("t3_hold_rdata", cpu_rdata, 32'h1234_5678);
      cyc();
    end
    i_stall = 0; #1;
    chk("t3_release_d_stall", d_stall, 1'b0);
    cyc();
    chk("t3_handshakes", hs_count - hs0, 1);
    chk("t3_req_cycles", req_cycles - rq0, 1);

    // Next instruction: same-cycle addr_ok and data_ok.
    issue(4'b0000, 2'd2, 32'h0000_0044, 32'h0); #1;
    chk("t4_c0_d_stall", d_stall, 1'b1);
    cyc(); bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'hCAFE_F00D; #1;
    chk("t4_c1_req", bus_req, 1'b1);
    chk("t4_c1_addr", bus_addr, 32'h0000_0044);
    cyc(); bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0; #1;
    chk("t4_c2_d_stall", d_stall, 1'b0);
    chk("t4_c2_rdata", cpu_rdata, 32'hCAFE_F00D);
    cyc(); cpu_en = 0;
    cyc();

    // Exception flush while waiting for data.
    issue(4'b0000, 2'd2, 32'h0000_0080, 32'h0);
    cyc(); bus_addr_ok = 1;
    cyc(); bus_addr_ok = 0; flush_except = 1; cpu_en = 0; #1;
    chk("t5_flush_d_stall", d_stall, 1'b1);
    cyc(); flush_except = 0; bus_data_ok = 1; bus_rdata = 32'hBADB_AD00; #1;
    chk("t5_data_d_stall", d_stall, 1'b1);
    cyc(); bus_data_ok = 0; bus_rdata = 0;
    issue(4'b0000, 2'd1, 32'h0000_0090, 32'h0); #1;
    chk("t5_rdata_kept", cpu_rdata, 32'hCAFE_F00D);
    chk("t5_new_start", d_stall, 1'b1);

    // Reset in DATA state.
    cyc(); bus_addr_ok = 1;
    cyc(); bus_addr_ok = 0; rst = 1;
    cyc(); rst = 0; cpu_en = 0; #1;
    chk("t6_req", bus_req, 1'b0);
    chk("t6_d_stall", d_stall, 1'b0);
    chk("t6_rdata", cpu_rdata, 32'h0);
    chk("t6_addr", bus_addr, 32'h0);
    chk("t6_size", bus_size, 2'd0);
    chk("t6_wr", bus_wr, 1'b0);
    chk("t6_wdata", bus_wdata, 32'h0);
    cyc();

    // Flush while idle: no request.
    issue(4'b1111, 2'd2, 32'h0000_00A0, 32'h7777_7777); flush_except = 1; #1;
    chk("t7_d_stall", d_stall, 1'b0);
    cyc(); flush_except = 0; cpu_en = 0; #1;
    chk("t7_req", bus_req, 1'b0);
    chk("t7_d_stall_after", d_stall, 1'b0);
    cyc(); cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/d_sram_bridge.md
Name: d_sram_bridge

Overview:
- Memory-side responder for the CPU data port. It accepts the M-stage load/store request (enable, byte enables, size, address, write data) and drives the pipeline's d_stall input.
- It converts each request into one transaction on an SRAM-like handshake bus (req/addr_ok/data_ok) toward the data memory/cache, and returns the read data to the CPU.
- It guarantees exactly one bus transaction per retired memory instruction, even while the pipeline remains stalled by i_stall.

Parameters:
- ADDR_W, 32, address width of cpu_addr/bus_addr
- DATA_W, 32, data width of write/read data

Ports:
- clk  in  1  single system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_en  in  1  M-stage instruction is a load/store with no pending exception
- cpu_wen  in  4  byte enables for stores; 4'b0000 = load
- cpu_size  in  2  access size: 0 byte, 1 half, 2 word
- cpu_addr  in  ADDR_W  byte address (aluoutM)
- cpu_wdata  in  DATA_W  store data, already lane-shifted
- cpu_rdata  out  DATA_W  read data returned to CPU (readdataM)
- cpu_longest_stall  in  1  global pipeline stall (OR of all stall sources)
- flush_except  in  1  exception flush of the pipeline
- d_stall  out  1  data-side stall request to hazard unit
- bus_req  out  1  transaction request
- bus_wr  out  1  1 = write, 0 = read
- bus_size  out  2  copy of latched cpu_size
- bus_addr  out  ADDR_W  latched address
- bus_wdata  out  DATA_W  latched write data
- bus_addr_ok  in  1  address/request accepted this cycle
- bus_data_ok  in  1  read data valid / write complete this cycle
- bus_rdata  in  DATA_W  read data, valid with bus_data_ok

Behaviour:
- Registers:
  - state ∈ {IDLE, ADDR, DATA}
  - do_finish: result delivered, waiting for the pipeline to advance
  - discard: transaction belongs to a flushed instruction
  - latched addr/wdata/size/wr
  - rdata register
- Reset (rst=1 at posedge): state=IDLE, do_finish=0, discard=0, bus_req=0, bus_wr=0, bus_size=0, bus_addr=0, bus_wdata=0, cpu_rdata=0. d_stall is therefore 0. Reset mid-transaction abandons it; the bus side shares rst.
- start = cpu_en & ~do_finish & ~flush_except & (state==IDLE).
- IDLE:
  - On start: latch cpu_addr/cpu_wdata/cpu_size, set wr=|cpu_wen, go to ADDR.
  - Otherwise stay.
- ADDR:
  - bus_req=1.
  - bus_addr/size/wr/wdata are held stable while bus_req=1.
  - bus_addr_ok=1 and bus_data_ok=0: go to DATA.
  - bus_addr_ok=1 and bus_data_ok=1 in the same cycle: complete immediately (see completion).
  - bus_addr_ok=0: stay with req held high.
- DATA:
  - bus_req=0.
  - On bus_data_ok: complete.
  - Ignore bus_addr_ok.
- Completion:
  - Go to IDLE.
  - If ~discard: latch cpu_rdata=bus_rdata (reads only; writes leave cpu_rdata unchanged) and set do_finish=1.
  - If discard: clear discard and leave do_finish=0.
- do_finish clears on any cycle with cpu_longest_stall=0; the instruction has then left M. It stays set while i_stall holds the pipeline, which prevents re-issue of the same access.
- d_stall (combinational) = start | (state != IDLE). Minimum latency, with addr_ok and data_ok both asserted one cycle after request:
  - cycle0: IDLE, d_stall=1
  - cycle1: ADDR, req=1
  - cycle2: DATA, data_ok
  - cycle3: d_stall=0, cpu_rdata valid
- flush_except in ADDR/DATA:
  - Set discard.
  - The bus transaction runs to completion; it cannot be cancelled.
  - d_stall remains 1 until it retires.
  - No new request is accepted before then.
- flush_except in IDLE: no request issued. It also clears do_finish.
- cpu_en=0: no bus activity, d_stall=0.

Test Plan:
- Word load, addr 0x00000010, addr_ok at cycle1, data_ok at cycle2 with rdata 0xDEADBEEF -> bus_req high exactly 1 cycle, bus_wr=0, bus_size=2; d_stall high cycles0-2; cpu_rdata=0xDEADBEEF at cycle3.
- Byte store, wen=4'b0100, addr 0x00000022, wdata 0x00AB0000; addr_ok held low 3 cycles -> bus_req stays 1 with addr/wdata stable for 4 cycles; bus_wr=1, bus_size=0; exactly one addr_ok handshake.
- Load completes while cpu_longest_stall=1 for 5 more cycles (i_stall) -> no second bus_req; d_stall=0 and cpu_rdata held. After the stall drops, do_finish=0 and the next cpu_en starts a new request.
- Same-cycle addr_ok and data_ok in ADDR -> direct return to IDLE; d_stall falls the next cycle; rdata latched correctly.
- flush_except pulses in DATA state -> data_ok still consumed; cpu_rdata unchanged; do_finish stays 0; d_stall drops after data_ok.
- rst asserted in DATA state -> next cycle all outputs at reset values, bus_req=0, d_stall=0.
